arb_mux_n_way: RTL and testbench

ARB_MUX_N_WAY -- requirements
Module: arb_mux_n_way

---
 rtl/arb_mux_n_way.sv | 96 +++++++++
 tb/tb_arb_mux_n_way.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/arb_mux_n_way.sv
// N-way arbitrating mux with fixed-select or round-robin grant feeding a single
// registered output stage with valid/ready handshaking on both sides.
module arb_mux_n_way #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8,
    parameter int SEL_W = $clog2(WAYS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WAYS*WIDTH-1:0]  in_data,
    input  logic [WAYS-1:0]        in_valid,
    output logic [WAYS-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       select,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [WIDTH-1:0] chan_data [WAYS];
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic             load_en;
    logic             xfer;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi]  = xfer && (gnt_idx == SEL_W'(gi));
        end
    endgenerate

    // Round-robin scans ptr+1 .. ptr+WAYS; the index wraps naturally since WAYS is a power of two.
    always_comb begin
        logic [SEL_W-1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (!mode) begin
            gnt_idx   = select;
            gnt_valid = in_valid[select];
        end else begin
            for (int k = 1; k <= WAYS; k++) begin
                cand = ptr_q + SEL_W'(k);
                if (!gnt_valid && in_valid[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = gnt_valid && load_en && !reset;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = chan_data[gnt_idx];
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ptr resets to WAYS-1 so the first round-robin search begins at channel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(WAYS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n_way.sv
// Directed bench for arb_mux_n_way (WIDTH=16, WAYS=8) with hand-computed expectations.
module tb_arb_mux_n_way;

    localparam int WIDTH = 16;
    localparam int WAYS  = 8;
    localparam int SEL_W = 3;

    logic                  clk;
    logic                  reset;
    logic [WAYS*WIDTH-1:0] in_data;
    logic [WAYS-1:0]       in_valid;
    logic [WAYS-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      select;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_chan;
    logic                  out_valid;
    logic                  out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    arb_mux_n_way #(.WIDTH(WIDTH), .WAYS(WAYS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i carries base + i*0x11.
    task automatic set_data(input logic [15:0] base);
        for (int i = 0; i < WAYS; i++)
            in_data[i*WIDTH +: WIDTH] = base + 16'(i * 17);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] ch, input logic [15:0] d);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".chan"},  32'(out_chan),  32'(ch));
        check({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b1;
        select    = '0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        set_data(16'hA000);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'h00);
        check_out("rst", 1'b0, 3'd0, 16'h0000);
        tick();
        check("rst_edge.valid", 32'(out_valid), 32'h0);
        check("rst_edge.in_ready", 32'(in_ready), 32'h00);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rr_first.in_ready", 32'(in_ready), 32'h01);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_out($sformatf("rr_seq%0d", i), 1'b1, 3'(i % 8), 16'hA000 + 16'((i % 8) * 17));
        end

        // Fixed select=5 ignores the other valid channels.
        set_data(16'h0000);
        mode   = 1'b0;
        select = 3'd5;
        #1;
        check("fix5.in_ready", 32'(in_ready), 32'h20);
        tick();
        check_out("fix5a", 1'b1, 3'd5, 16'h0055);
        check("fix5.in_ready2", 32'(in_ready), 32'h20);
        tick();
        check_out("fix5b", 1'b1, 3'd5, 16'h0055);

        select = 3'd2;
        #1;
        check("fix2.in_ready", 32'(in_ready), 32'h04);
        tick();
        check_out("fix2", 1'b1, 3'd2, 16'h0022);
        mode = 1'b1;
        #1;
        check("switch.in_ready", 32'(in_ready), 32'h08);
        tick();
        check_out("switch", 1'b1, 3'd3, 16'h0033);

        // Park ptr at 7, then check round-robin wrap between ch0 and ch7.
        mode   = 1'b0;
        select = 3'd7;
        tick();
        check_out("fix7", 1'b1, 3'd7, 16'h0077);
        set_data(16'h1000);
        mode     = 1'b1;
        in_valid = 8'b1000_0001;
        #1;
        check("wrap0.in_ready", 32'(in_ready), 32'h01);
        tick();
        check_out("wrap0", 1'b1, 3'd0, 16'h1000);
        check("wrap7.in_ready", 32'(in_ready), 32'h80);
        tick();
        check_out("wrap7", 1'b1, 3'd7, 16'h1077);
        check("wrap0b.in_ready", 32'(in_ready), 32'h01);
        tick();
        check_out("wrap0b", 1'b1, 3'd0, 16'h1000);

        // Fixed select whose valid is low: no grant, register drains and holds.
        mode     = 1'b0;
        select   = 3'd3;
        in_valid = 8'hF7;
        #1;
        check("nogrant.in_ready", 32'(in_ready), 32'h00);
        tick();
        check_out("drain", 1'b0, 3'd0, 16'h1000);

        // Backpressure.
        mode     = 1'b1;
        in_valid = 8'hFF;
        #1;
        check("bp_load.in_ready", 32'(in_ready), 32'h02);
        tick();
        check_out("bp_load", 1'b1, 3'd1, 16'h1011);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h00);
            tick();
            check_out($sformatf("bp%0d", i), 1'b1, 3'd1, 16'h1011);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel.in_ready", 32'(in_ready), 32'h04);
        tick();
        check_out("bp_rel", 1'b1, 3'd2, 16'h1022);

        // Asynchronous reset between edges while holding a word.
        #2;
        reset = 1'b1;
        #1;
        check_out("arst", 1'b0, 3'd0, 16'h0000);
        check("arst.in_ready", 32'(in_ready), 32'h00);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 8'h0C;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'h04);
        tick();
        check_out("post_rst", 1'b1, 3'd2, 16'h1022);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
